// File: rtl/mem_arbiter_if.sv
// AXI4-Lite bus between mem_arbiter (master) and the shared memory subordinate (slave).
interface mem_arbiter_if #(
   parameter int AXI_AWIDTH = 32,
   parameter int AXI_DWIDTH = 32
);
   logic [AXI_AWIDTH-1:0]   AWADDR;
   logic                    AWVALID;
   logic                    AWREADY;
   logic [AXI_DWIDTH-1:0]   WDATA;
   logic [AXI_DWIDTH/8-1:0] WSTRB;
   logic                    WVALID;
   logic                    WREADY;
   logic [1:0]              BRESP;
   logic                    BVALID;
   logic                    BREADY;
   logic [AXI_AWIDTH-1:0]   ARADDR;
   logic                    ARVALID;
   logic                    ARREADY;
   logic [AXI_DWIDTH-1:0]   RDATA;
   logic [1:0]              RRESP;
   logic                    RVALID;
   logic                    RREADY;

   modport master (
      output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite subordinate between instruction fetch and data ports.
// Optional watchdog on stalled transactions: define ARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int AXI_AWIDTH     = 32,
   parameter int AXI_DWIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    AXI_ACLK,
   input  logic                    AXI_ARESET,

   input  logic                    if_req,
   input  logic [AXI_AWIDTH-1:0]   if_addr,
   output logic                    if_ready,
   output logic [AXI_DWIDTH-1:0]   if_rdata,
   output logic                    if_err,

   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [AXI_AWIDTH-1:0]   d_addr,
   input  logic [AXI_DWIDTH-1:0]   d_wdata,
   input  logic [AXI_DWIDTH/8-1:0] d_wstrb,
   output logic                    d_ready,
   output logic [AXI_DWIDTH-1:0]   d_rdata,
   output logic                    d_err,

   mem_arbiter_if.master           M_AXI
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t                  state;
   logic                    last_d;
   logic                    gnt_d;
   logic                    grant_if;
   logic                    grant_d;
   logic                    tmo_hit;
   logic                    resp_done;
   logic [AXI_DWIDTH-1:0]   resp_data;
   logic                    resp_err;

   // On a tie the requester that did not win last time gets the bus.
   assign grant_if = if_req && (!d_req || last_d);
   assign grant_d  = d_req  && (!if_req || !last_d);

`ifdef ARB_TIMEOUT_EN
   localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [TMO_W-1:0] tmo_cnt;
   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   // Watchdog absent: never fires, the comparison only keeps the parameter referenced.
   assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      resp_done = 1'b0;
      resp_data = '0;
      resp_err  = 1'b0;
      case (state)
         RD: begin
            if (M_AXI.RVALID) begin
               resp_done = 1'b1;
               resp_data = M_AXI.RDATA;
               resp_err  = (M_AXI.RRESP != 2'b00);
            end else if (tmo_hit) begin
               resp_done = 1'b1;
               resp_data = AXI_DWIDTH'(32'hDEADBEEF);
               resp_err  = 1'b1;
            end
         end
         WR: begin
            if (M_AXI.BVALID) begin
               resp_done = 1'b1;
               resp_err  = (M_AXI.BRESP != 2'b00);
            end else if (tmo_hit) begin
               resp_done = 1'b1;
               resp_data = AXI_DWIDTH'(32'hDEADBEEF);
               resp_err  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Grant in IDLE, run one AXI transaction, then pulse the winner's ready from DONE.
   always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
      if (AXI_ARESET) begin
         state         <= IDLE;
         last_d        <= 1'b1;
         gnt_d         <= 1'b0;
         M_AXI.AWADDR  <= '0;
         M_AXI.AWVALID <= 1'b0;
         M_AXI.WDATA   <= '0;
         M_AXI.WSTRB   <= '0;
         M_AXI.WVALID  <= 1'b0;
         M_AXI.BREADY  <= 1'b0;
         M_AXI.ARADDR  <= '0;
         M_AXI.ARVALID <= 1'b0;
         M_AXI.RREADY  <= 1'b0;
         if_ready      <= 1'b0;
         if_rdata      <= '0;
         if_err        <= 1'b0;
         d_ready       <= 1'b0;
         d_rdata       <= '0;
         d_err         <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         tmo_cnt       <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (grant_if || grant_d) begin
                  gnt_d  <= grant_d;
                  last_d <= grant_d;
                  if (grant_d && d_we) begin
                     M_AXI.AWADDR  <= d_addr;
                     M_AXI.WDATA   <= d_wdata;
                     M_AXI.WSTRB   <= d_wstrb;
                     M_AXI.AWVALID <= 1'b1;
                     M_AXI.WVALID  <= 1'b1;
                     M_AXI.BREADY  <= 1'b1;
                     state         <= WR;
                  end else begin
                     M_AXI.ARADDR  <= grant_d ? d_addr : if_addr;
                     M_AXI.ARVALID <= 1'b1;
                     M_AXI.RREADY  <= 1'b1;
                     state         <= RD;
                  end
               end
            end
            RD: begin
               if (M_AXI.ARREADY) M_AXI.ARVALID <= 1'b0;
            end
            WR: begin
               if (M_AXI.AWREADY) M_AXI.AWVALID <= 1'b0;
               if (M_AXI.WREADY)  M_AXI.WVALID  <= 1'b0;
            end
            DONE: begin
               if_ready <= 1'b0;
               if_rdata <= '0;
               if_err   <= 1'b0;
               d_ready  <= 1'b0;
               d_rdata  <= '0;
               d_err    <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase

`ifdef ARB_TIMEOUT_EN
         if (state == IDLE) tmo_cnt <= '0;
         else if (state == RD || state == WR) tmo_cnt <= tmo_cnt + 1'b1;
`endif

         if (resp_done) begin
            M_AXI.ARVALID <= 1'b0;
            M_AXI.RREADY  <= 1'b0;
            M_AXI.AWVALID <= 1'b0;
            M_AXI.WVALID  <= 1'b0;
            M_AXI.BREADY  <= 1'b0;
            if (gnt_d) begin
               d_ready <= 1'b1;
               d_rdata <= resp_data;
               d_err   <= resp_err;
            end else begin
               if_ready <= 1'b1;
               if_rdata <= resp_data;
               if_err   <= resp_err;
            end
            state <= DONE;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: AXI4-Lite memory model with random wait states and
// response codes, checked against a transaction-level reference of memory contents and grant order.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 16;

   logic          AXI_ACLK = 1'b0;
   logic          AXI_ARESET;
   logic          if_req, if_ready, if_err;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          d_req, d_we, d_ready, d_err;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic [3:0]    d_wstrb;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 AXI_ACLK = ~AXI_ACLK;

   mem_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) bus ();

   mem_arbiter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .AXI_ACLK   (AXI_ACLK),
      .AXI_ARESET (AXI_ARESET),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_ready   (if_ready),
      .if_rdata   (if_rdata),
      .if_err     (if_err),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_wstrb    (d_wstrb),
      .d_ready    (d_ready),
      .d_rdata    (d_rdata),
      .d_err      (d_err),
      .M_AXI      (bus.master)
   );

   // Subordinate knobs, set by the test tasks between transactions.
   bit         mute = 1'b0;
   int         ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
   logic [1:0] rresp_next = 2'b00, bresp_next = 2'b00;

   logic [31:0] sub_mem [0:63];
   logic [31:0] ref_mem [0:63];
   int          ar_cnt, aw_cnt, w_cnt, r_left, b_left;
   bit          r_pend, b_pend, aw_got, w_got;
   logic [31:0] r_addr, wa_addr, w_data_q;
   logic [3:0]  w_strb_q;
   logic [31:0] last_araddr;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // AXI4-Lite memory model: registered readies/valids with per-channel wait states.
   always @(posedge AXI_ACLK or posedge AXI_ARESET) begin : sub_model
      logic        aw_now, w_now;
      logic [31:0] a, wd;
      logic [3:0]  ws;
      if (AXI_ARESET) begin
         bus.ARREADY <= 1'b0; bus.RVALID <= 1'b0; bus.RDATA <= '0; bus.RRESP <= 2'b00;
         bus.AWREADY <= 1'b0; bus.WREADY <= 1'b0; bus.BVALID <= 1'b0; bus.BRESP <= 2'b00;
         ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_left <= 0; b_left <= 0;
         r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
         r_addr <= '0; wa_addr <= '0; w_data_q <= '0; w_strb_q <= '0;
         for (int i = 0; i < 64; i++) sub_mem[i] <= '0;
      end else begin
         bus.ARREADY <= 1'b0;
         bus.AWREADY <= 1'b0;
         bus.WREADY  <= 1'b0;
         if (bus.RVALID && bus.RREADY) bus.RVALID <= 1'b0;
         if (bus.BVALID && bus.BREADY) bus.BVALID <= 1'b0;
         if (!mute) begin
            if (bus.ARVALID && !bus.ARREADY) begin
               if (ar_cnt >= ar_wait) begin
                  bus.ARREADY <= 1'b1;
                  ar_cnt      <= 0;
                  if (r_wait == 0) begin
                     bus.RVALID <= 1'b1;
                     bus.RDATA  <= sub_mem[bus.ARADDR[7:2]];
                     bus.RRESP  <= rresp_next;
                  end else begin
                     r_pend <= 1'b1;
                     r_left <= r_wait;
                     r_addr <= bus.ARADDR;
                  end
               end else ar_cnt <= ar_cnt + 1;
            end
            if (r_pend) begin
               if (r_left == 1) begin
                  bus.RVALID <= 1'b1;
                  bus.RDATA  <= sub_mem[r_addr[7:2]];
                  bus.RRESP  <= rresp_next;
                  r_pend     <= 1'b0;
               end else r_left <= r_left - 1;
            end

            aw_now = bus.AWVALID && !bus.AWREADY && !aw_got && (aw_cnt >= aw_wait);
            w_now  = bus.WVALID  && !bus.WREADY  && !w_got  && (w_cnt  >= w_wait);
            if (bus.AWVALID && !bus.AWREADY && !aw_got && !aw_now) aw_cnt <= aw_cnt + 1;
            if (bus.WVALID  && !bus.WREADY  && !w_got  && !w_now)  w_cnt  <= w_cnt + 1;
            if (aw_now) begin bus.AWREADY <= 1'b1; aw_got <= 1'b1; wa_addr <= bus.AWADDR; aw_cnt <= 0; end
            if (w_now)  begin bus.WREADY <= 1'b1; w_got <= 1'b1; w_data_q <= bus.WDATA; w_strb_q <= bus.WSTRB; w_cnt <= 0; end
            if ((aw_got || aw_now) && (w_got || w_now) && !b_pend && !bus.BVALID) begin
               a  = aw_now ? bus.AWADDR : wa_addr;
               wd = w_now  ? bus.WDATA  : w_data_q;
               ws = w_now  ? bus.WSTRB  : w_strb_q;
               sub_mem[a[7:2]] <= merge(sub_mem[a[7:2]], wd, ws);
               aw_got <= 1'b0;
               w_got  <= 1'b0;
               if (b_wait == 0) begin
                  bus.BVALID <= 1'b1;
                  bus.BRESP  <= bresp_next;
               end else begin
                  b_pend <= 1'b1;
                  b_left <= b_wait;
               end
            end
            if (b_pend) begin
               if (b_left == 1) begin
                  bus.BVALID <= 1'b1;
                  bus.BRESP  <= bresp_next;
                  b_pend     <= 1'b0;
               end else b_left <= b_left - 1;
            end
         end
      end
   end

   always @(negedge AXI_ACLK) if (bus.ARVALID) last_araddr <= bus.ARADDR;

   task automatic do_reset();
      AXI_ARESET = 1'b1;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
      mute = 1'b0;
      ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
      rresp_next = 2'b00; bresp_next = 2'b00;
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      repeat (2) @(negedge AXI_ACLK);
      AXI_ARESET = 1'b0;
   endtask

   // Issue one request, wait (bounded) for its ready; lat = negedges from request to ready, -1 if none.
   task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata, output logic err,
                          output int lat, output bit pulse_ok);
      bit seen;
      seen = 1'b0; lat = -1; rdata = 'x; err = 1'bx; pulse_ok = 1'b0;
      @(negedge AXI_ACLK);
      if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb; end
      else begin if_req = 1'b1; if_addr = addr; end
      for (int i = 1; i <= 300 && !seen; i++) begin
         @(negedge AXI_ACLK);
         if (is_d ? d_ready : if_ready) begin
            seen  = 1'b1;
            lat   = i;
            rdata = is_d ? d_rdata : if_rdata;
            err   = is_d ? d_err : if_err;
         end
      end
      if (is_d) d_req = 1'b0; else if_req = 1'b0;
      if (seen) begin
         @(negedge AXI_ACLK);
         pulse_ok = is_d ? !d_ready : !if_ready;
      end
   endtask

   function automatic logic [206:0] all_outs();
      return {if_ready, d_ready, if_rdata, d_rdata, if_err, d_err,
              bus.ARVALID, bus.RREADY, bus.AWVALID, bus.WVALID, bus.BREADY,
              bus.ARADDR, bus.AWADDR, bus.WDATA, bus.WSTRB};
   endfunction

   task automatic test_reset();
      logic [31:0] rd; logic er; int lat; bit pok;
      AXI_ARESET = 1'b1;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      repeat (2) @(negedge AXI_ACLK);
      n_cmp++;
      if (all_outs() !== '0) begin n_fail++; $display("[TB] FAIL reset_outs: got %h expected 0", all_outs()); end
      AXI_ARESET = 1'b0;

      mute = 1'b1;
      @(negedge AXI_ACLK);
      if_req = 1'b1; if_addr = 32'h40;
      @(negedge AXI_ACLK);
      n_cmp++;
      if (bus.ARVALID !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_arvalid: got %b expected 1", bus.ARVALID); end
      @(negedge AXI_ACLK);
      #2 AXI_ARESET = 1'b1;
      #1;
      n_cmp++;
      if (all_outs() !== '0) begin n_fail++; $display("[TB] FAIL midrd_reset_outs: got %h expected 0", all_outs()); end
      @(negedge AXI_ACLK);
      AXI_ARESET = 1'b0;
      n_cmp++;
      if (bus.ARVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_idle: got %b expected 0", bus.ARVALID); end
      @(negedge AXI_ACLK);
      n_cmp++;
      if ({bus.ARVALID, bus.ARADDR} !== {1'b1, 32'h40}) begin
         n_fail++; $display("[TB] FAIL regrant_ar: got %b/%h expected 1/00000040", bus.ARVALID, bus.ARADDR);
      end
      mute = 1'b0;
      lat = -1; rd = 'x;
      for (int i = 0; i < 50 && lat < 0; i++) begin
         @(negedge AXI_ACLK);
         if (if_ready) begin lat = i; rd = if_rdata; end
      end
      if_req = 1'b0;
      @(negedge AXI_ACLK);
      n_cmp++;
      if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL regrant_done: got %h expected 00000000", rd); end
      er = 1'b0; pok = 1'b0;
   endtask

   task automatic test_fetch();
      logic [31:0] rd; logic er; int lat; bit pok;
      do_reset();
      run_txn(1'b1, 1'b1, 32'h10, 32'h00000013, 4'hF, rd, er, lat, pok);
      ref_mem[4] = 32'h00000013;
      run_txn(1'b0, 1'b0, 32'h10, '0, '0, rd, er, lat, pok);
      n_cmp++;
      if (last_araddr !== 32'h10) begin n_fail++; $display("[TB] FAIL fetch_araddr: got %h expected 00000010", last_araddr); end
      n_cmp++;
      if (lat !== 3) begin n_fail++; $display("[TB] FAIL fetch_latency: got %0d expected 3", lat); end
      n_cmp++;
      if ({rd, er} !== {ref_mem[4], 1'b0}) begin
         n_fail++; $display("[TB] FAIL fetch_data: got %h/%b expected %h/0", rd, er, ref_mem[4]);
      end
      n_cmp++;
      if (pok !== 1'b1) begin n_fail++; $display("[TB] FAIL fetch_pulse: got %b expected 1", pok); end
   endtask

   task automatic test_write_read();
      logic [31:0] rd; logic er; int lat; bit pok;
      do_reset();
      run_txn(1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, rd, er, lat, pok);
      run_txn(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'b0011, rd, er, lat, pok);
      n_cmp++;
      if ({rd, er, lat} !== {32'h0, 1'b0, 32'sd3}) begin
         n_fail++; $display("[TB] FAIL write_resp: got %h/%b/%0d expected 00000000/0/3", rd, er, lat);
      end
      run_txn(1'b1, 1'b0, 32'h20, '0, '0, rd, er, lat, pok);
      n_cmp++;
      if (rd !== 32'hFFFFA5A5) begin n_fail++; $display("[TB] FAIL strobe_read: got %h expected FFFFA5A5", rd); end
      n_cmp++;
      if ({er, pok} !== 2'b01) begin n_fail++; $display("[TB] FAIL strobe_read_flags: got %b expected 01", {er, pok}); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er; int lat; bit pok;
      int order[$]; int when[$]; logic [31:0] data[$];
      bit overlap, wide, prev_if, prev_d, last_m;
      int exp_who;
      do_reset();
      run_txn(1'b1, 1'b1, 32'h34, 32'hAAAA0001, 4'hF, rd, er, lat, pok);
      run_txn(1'b1, 1'b1, 32'h38, 32'hBBBB0002, 4'hF, rd, er, lat, pok);
      ref_mem[13] = 32'hAAAA0001;
      ref_mem[14] = 32'hBBBB0002;
      overlap = 1'b0; wide = 1'b0; prev_if = 1'b0; prev_d = 1'b0;
      @(negedge AXI_ACLK);
      if_req = 1'b1; if_addr = 32'h34;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h38;
      for (int cyc = 1; cyc <= 80 && order.size() < 6; cyc++) begin
         @(negedge AXI_ACLK);
         if (bus.ARVALID && (bus.AWVALID || bus.WVALID)) overlap = 1'b1;
         if (if_ready && d_ready) overlap = 1'b1;
         if ((if_ready && prev_if) || (d_ready && prev_d)) wide = 1'b1;
         prev_if = if_ready; prev_d = d_ready;
         if (if_ready) begin order.push_back(0); when.push_back(cyc); data.push_back(if_rdata); end
         if (d_ready)  begin order.push_back(1); when.push_back(cyc); data.push_back(d_rdata); end
      end
      if_req = 1'b0; d_req = 1'b0;
      repeat (4) @(negedge AXI_ACLK);
      n_cmp++;
      if (order.size() != 6) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d expected 6", order.size()); end
      last_m = 1'b1;
      for (int k = 0; k < order.size(); k++) begin
         exp_who = last_m ? 0 : 1;
         last_m  = (exp_who == 1);
         n_cmp++;
         if (order[k] !== exp_who) begin n_fail++; $display("[TB] FAIL b2b_grant%0d: got %0d expected %0d", k, order[k], exp_who); end
         n_cmp++;
         if (data[k] !== ref_mem[exp_who ? 14 : 13]) begin
            n_fail++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", k, data[k], ref_mem[exp_who ? 14 : 13]);
         end
         if (k > 0) begin
            n_cmp++;
            if (when[k] - when[k-1] !== 4) begin
               n_fail++; $display("[TB] FAIL b2b_spacing%0d: got %0d expected 4", k, when[k] - when[k-1]);
            end
         end
      end
      if (when.size() > 0) begin
         n_cmp++;
         if (when[0] !== 3) begin n_fail++; $display("[TB] FAIL b2b_first_latency: got %0d expected 3", when[0]); end
      end
      n_cmp++;
      if ({overlap, wide} !== 2'b00) begin n_fail++; $display("[TB] FAIL b2b_overlap_width: got %b expected 00", {overlap, wide}); end
   endtask

   task automatic test_error();
      logic [31:0] rd; logic er; int lat; bit pok;
      do_reset();
      rresp_next = 2'b10;
      run_txn(1'b1, 1'b0, 32'h08, '0, '0, rd, er, lat, pok);
      n_cmp++;
      if (er !== 1'b1) begin n_fail++; $display("[TB] FAIL rresp_slverr: got %b expected 1", er); end
      rresp_next = 2'b00;
      run_txn(1'b1, 1'b0, 32'h08, '0, '0, rd, er, lat, pok);
      n_cmp++;
      if (er !== 1'b0) begin n_fail++; $display("[TB] FAIL rresp_okay: got %b expected 0", er); end
      bresp_next = 2'b11;
      run_txn(1'b1, 1'b1, 32'h0C, 32'h12345678, 4'hF, rd, er, lat, pok);
      n_cmp++;
      if ({er, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("[TB] FAIL bresp_decerr: got %b/%h expected 1/00000000", er, rd); end
      bresp_next = 2'b00;
      rresp_next = 2'b01;
      run_txn(1'b0, 1'b0, 32'h0C, '0, '0, rd, er, lat, pok);
      n_cmp++;
      if ({er, rd} !== {1'b1, 32'h12345678}) begin n_fail++; $display("[TB] FAIL fetch_exokay: got %b/%h expected 1/12345678", er, rd); end
      rresp_next = 2'b00;
   endtask

   task automatic test_random();
      logic [31:0] rd, addr, wdata, exp_data; logic er, exp_err; int lat, exp_lat; bit pok, is_d, we;
      logic [3:0] wstrb; logic [1:0] resp; int idx;
      do_reset();
      for (int n = 0; n < 24; n++) begin
         is_d  = ($urandom_range(0, 2) != 0);
         we    = is_d && ($urandom_range(0, 1) == 1);
         idx   = $urandom_range(0, 15);
         addr  = 32'(idx) << 2;
         wdata = $urandom;
         wstrb = 4'($urandom_range(0, 15));
         ar_wait = $urandom_range(0, 3); r_wait = $urandom_range(0, 3);
         aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3); b_wait = $urandom_range(0, 3);
         resp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
         rresp_next = resp; bresp_next = resp;
         exp_err = (resp != 2'b00);
         if (we) begin
            exp_lat  = 3 + ((aw_wait > w_wait) ? aw_wait : w_wait) + b_wait;
            exp_data = '0;
            ref_mem[idx] = merge(ref_mem[idx], wdata, wstrb);
         end else begin
            exp_lat  = 3 + ar_wait + r_wait;
            exp_data = ref_mem[idx];
         end
         run_txn(is_d, we, addr, wdata, wstrb, rd, er, lat, pok);
         n_cmp++;
         if (rd !== exp_data) begin n_fail++; $display("[TB] FAIL rand%0d_data: got %h expected %h", n, rd, exp_data); end
         n_cmp++;
         if (er !== exp_err) begin n_fail++; $display("[TB] FAIL rand%0d_err: got %b expected %b", n, er, exp_err); end
         n_cmp++;
         if (lat !== exp_lat) begin n_fail++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", n, lat, exp_lat); end
         n_cmp++;
         if (pok !== 1'b1) begin n_fail++; $display("[TB] FAIL rand%0d_pulse: got %b expected 1", n, pok); end
      end
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] rd; logic er; int lat; bit pok;
      do_reset();
      mute = 1'b1;
      run_txn(1'b0, 1'b0, 32'h04, '0, '0, rd, er, lat, pok);
      n_cmp++;
      if ({rd, er} !== {32'hDEADBEEF, 1'b1}) begin n_fail++; $display("[TB] FAIL timeout_resp: got %h/%b expected DEADBEEF/1", rd, er); end
      n_cmp++;
      if (lat !== TMO + 1) begin n_fail++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", lat, TMO + 1); end
      mute = 1'b0;
      run_txn(1'b0, 1'b0, 32'h04, '0, '0, rd, er, lat, pok);
      n_cmp++;
      if ({rd, er, lat} !== {32'h0, 1'b0, 32'sd3}) begin
         n_fail++; $display("[TB] FAIL timeout_recover: got %h/%b/%0d expected 00000000/0/3", rd, er, lat);
      end
   endtask
`endif

   initial begin
      $display("[TB] mem_arbiter bench start");
      test_reset();
      test_fetch();
      test_write_read();
      test_back_to_back();
      test_error();
      test_random();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] simulation time limit");
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter
Two-requester arbiter that shares the single AXI4-Lite memory subordinate between the RV32I core's instruction-fetch port (read-only) and data port (load/store). It accepts simple req/ready transactions from each requester and sequences one AXI4-Lite read or write at a time. Arbitration is round-robin, and the subordinate's response code is reported back to the winner. It sits between the core and the memory model, and is the only AXI master on that bus.
## Interface
- AXI_AWIDTH, 32, address width of requester and AXI address ports
- AXI_DWIDTH, 32, data width; WSTRB width is AXI_DWIDTH/8
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)
- AXI_ACLK  in  1  single clock, all logic on rising edge
- AXI_ARESET  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held with if_addr stable until if_ready
- if_addr  in  AXI_AWIDTH  fetch byte address
- if_ready  out  1  one-cycle completion pulse for fetch
- if_rdata  out  AXI_DWIDTH  fetch data, valid while if_ready=1
- if_err  out  1  fetch error, valid while if_ready=1
- d_req  in  1  data request, held with d_we/d_addr/d_wdata/d_wstrb stable until d_ready
- d_we  in  1  1=write, 0=read
- d_addr  in  AXI_AWIDTH  data byte address
- d_wdata  in  AXI_DWIDTH  store data
- d_wstrb  in  AXI_DWIDTH/8  store byte enables
- d_ready / d_rdata / d_err  out  1 / AXI_DWIDTH / 1  as the if_* outputs
- M_AXI_AWADDR/AWVALID out, AWREADY in  AXI_AWIDTH/1/1  write address channel
- M_AXI_WDATA/WSTRB/WVALID out, WREADY in  AXI_DWIDTH/AXI_DWIDTH/8/1/1  write data channel
- M_AXI_BRESP/BVALID in, BREADY out  2/1/1  write response channel
- M_AXI_ARADDR/ARVALID out, ARREADY in  AXI_AWIDTH/1/1  read address channel
- M_AXI_RDATA/RRESP/RVALID in, RREADY out  AXI_DWIDTH/2/1/1  read data channel
## Operation
- States: IDLE, RD, WR, DONE.
- IDLE: sample if_req/d_req. If only one is high, grant it. If both are high, grant the one not granted last. `last` resets to DATA, so fetch wins the first tie. The grant latches the address, data, strobe and we into internal registers. Fetch always goes to RD; data goes to RD when d_we=0 and to WR when d_we=1.
- RD: ARVALID=1 until ARREADY is sampled high. RREADY=1 for the whole state, including the address phase (the subordinate requires ARVALID&RREADY together). On RVALID, capture RDATA and RRESP and go to DONE. ARREADY and RVALID may arrive in the same cycle.
- WR: AWVALID and WVALID are both asserted. Each drops independently after its own READY is sampled. BREADY=1 for the whole state. On BVALID, capture BRESP and go to DONE. AWREADY, WREADY and BVALID may all arrive in the same cycle.
- DONE: pulse the granted ready for exactly one cycle with rdata and err. err = (captured RESP != 2'b00). For writes, rdata = 0. All AXI valids and readys are 0. Requests are ignored; the next state is always IDLE.
- The non-granted requester waits; its req stays pending and it wins the next IDLE arbitration.
- A requester must drop req, or present a new transaction, in the cycle after its ready. That new request is sampled in IDLE.
- Reset (async, any state): state=IDLE, last=DATA. All outputs are 0: every VALID/READY, every addr/data/strb, if_ready, d_ready, if_rdata, d_rdata, if_err, d_err. An in-flight transaction is abandoned with no ready pulse.
## Timing
- Zero-wait subordinate (registered ready/valid one cycle after valid):
  - request sampled in IDLE at edge 0;
  - ARVALID/AWVALID high in cycle 1;
  - response seen at edge 2;
  - ready in cycle 3.
- Total: 3 cycles request-to-ready, 4 cycles per transaction.
- Subordinate wait states add 1:1 to latency.
- Back-to-back alternating fetch/data with both reqs held: grants alternate IF, D, IF, …, one completion every 4 cycles.
- Outputs are registered; no combinational path from M_AXI_* inputs to requester outputs.
## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entry to RD/WR and increments each cycle in RD/WR.
  - When it reaches TIMEOUT_CYCLES without RVALID/BVALID: drop all valids and readys and go to DONE with err=1 and rdata=32'hDEADBEEF.
- Not defined: no counter; RD/WR wait indefinitely.
## Test plan
- Reset with if_req=1 asserted mid-RD -> all outputs 0 immediately; after release, fetch re-granted, ARVALID high 1 cycle after IDLE sample.
- if_req only, if_addr=0x10, mem[4]=0x00000013 -> ARADDR=0x10, if_ready pulse 3 cycles after sample, if_rdata=0x00000013, if_err=0.
- d_req write d_addr=0x20, d_wdata=0xA5A5A5A5, d_wstrb=4'b0011, then read 0x20 (mem preset 0xFFFFFFFF) -> d_ready each, read returns 0xFFFFA5A5.
- if_req and d_req high together from reset, held -> grant order IF, D, IF, D; each ready single-cycle; no overlapping AXI valids.
- Subordinate returns RRESP=2'b10 -> d_err=1 with d_ready; next transaction with OKAY -> d_err=0.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, subordinate never asserts RVALID -> if_ready with if_err=1, if_rdata=0xDEADBEEF after 16 RD cycles; arbiter returns to IDLE.
